// File: rtl/perceptron_sample_loader_if.sv
// Stream interface between the byte loader, its upstream byte source and the
// downstream perceptron trainer.
interface perceptron_sample_loader_if #(
   parameter int INP_DIM   = 2,
   parameter int N_SAMPLES = 3,
   parameter int EPOCHS    = 4
);
   localparam int IDX_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
   localparam int EP_W  = (EPOCHS > 1) ? $clog2(EPOCHS) : 1;

   logic [7:0]           in_data;
   logic                 in_valid;
   logic                 in_ready;
   logic [8*INP_DIM-1:0] out_x;
   logic [7:0]           out_y;
   logic [IDX_W-1:0]     out_idx;
   logic [EP_W-1:0]      out_epoch;
   logic                 out_valid;
   logic                 out_ready;
   logic                 out_last;
   logic                 done;

   // slave: the loader itself; master: byte source plus trainer
   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_x, out_y, out_idx, out_epoch, out_valid, out_last, done
   );

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_x, out_y, out_idx, out_epoch, out_valid, out_last, done
   );
endinterface

// File: rtl/perceptron_sample_loader.sv
// Loads one training set from a byte stream into a register array, then
// replays it to the trainer for EPOCHS passes.
module perceptron_sample_slot #(
   parameter int INP_DIM = 2,
   parameter int B_W     = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 wr_en,
   input  logic [B_W-1:0]       wr_sel,
   input  logic [7:0]           wr_data,
   output logic [8*INP_DIM-1:0] x,
   output logic [7:0]           y
);
   logic [7:0] label_q;

   for (genvar k = 0; k < INP_DIM; k++) begin : g_feat
      logic [7:0] feat_q;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)                               feat_q <= '0;
         else if (wr_en && wr_sel == B_W'(k))     feat_q <= wr_data;
      end
      assign x[8*k +: 8] = feat_q;
   end

   // byte position INP_DIM is the label
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                  label_q <= '0;
      else if (wr_en && wr_sel == B_W'(INP_DIM))   label_q <= wr_data;
   end

   assign y = label_q;
endmodule

module perceptron_sample_loader #(
   parameter int INP_DIM   = 2,
   parameter int N_SAMPLES = 3,
   parameter int EPOCHS    = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           clear,
   perceptron_sample_loader_if.slave      bus
);
   localparam int IDX_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
   localparam int EP_W  = (EPOCHS > 1) ? $clog2(EPOCHS) : 1;
   localparam int B_W   = $clog2(INP_DIM + 1);
   localparam int X_W   = 8 * INP_DIM;

   typedef enum logic [1:0] {S_LOAD, S_REPLAY, S_DONE} state_t;

   state_t           state, state_nxt;
   logic [B_W-1:0]   b, b_nxt;
   logic [IDX_W-1:0] s, s_nxt;
   logic [IDX_W-1:0] idx, idx_nxt;
   logic [EP_W-1:0]  epoch, epoch_nxt;

   logic in_fire, out_fire;
   logic [N_SAMPLES-1:0][X_W-1:0] slot_x;
   logic [N_SAMPLES-1:0][7:0]     slot_y;
   logic [X_W-1:0] sel_x;
   logic [7:0]     sel_y;

   // clear blocks both handshakes in its cycle
   assign in_fire  = (state == S_LOAD) && bus.in_valid && !clear;
   assign out_fire = (state == S_REPLAY) && bus.out_ready && !clear;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_LOAD;
         b     <= '0;
         s     <= '0;
         idx   <= '0;
         epoch <= '0;
      end else begin
         state <= state_nxt;
         b     <= b_nxt;
         s     <= s_nxt;
         idx   <= idx_nxt;
         epoch <= epoch_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      b_nxt     = b;
      s_nxt     = s;
      idx_nxt   = idx;
      epoch_nxt = epoch;
      if (clear) begin
         state_nxt = S_LOAD;
         b_nxt     = '0;
         s_nxt     = '0;
         idx_nxt   = '0;
         epoch_nxt = '0;
      end else begin
         case (state)
            S_LOAD: begin
               if (in_fire) begin
                  if (b == B_W'(INP_DIM)) begin
                     b_nxt = '0;
                     if (s == IDX_W'(N_SAMPLES - 1)) begin
                        s_nxt     = '0;
                        idx_nxt   = '0;
                        epoch_nxt = '0;
                        state_nxt = S_REPLAY;
                     end else begin
                        s_nxt = s + IDX_W'(1);
                     end
                  end else begin
                     b_nxt = b + B_W'(1);
                  end
               end
            end
            S_REPLAY: begin
               if (out_fire) begin
                  if (idx == IDX_W'(N_SAMPLES - 1)) begin
                     idx_nxt = '0;
                     if (epoch == EP_W'(EPOCHS - 1)) state_nxt = S_DONE;
                     else                              epoch_nxt = epoch + EP_W'(1);
                  end else begin
                     idx_nxt = idx + IDX_W'(1);
                  end
               end
            end
            S_DONE:  state_nxt = S_DONE;
            default: state_nxt = S_LOAD;
         endcase
      end
   end

   for (genvar i = 0; i < N_SAMPLES; i++) begin : g_slot
      perceptron_sample_slot #(.INP_DIM(INP_DIM), .B_W(B_W)) u_slot (
         .clk     (clk),
         .rst_n   (rst_n),
         .wr_en   (in_fire && s == IDX_W'(i)),
         .wr_sel  (b),
         .wr_data (bus.in_data),
         .x       (slot_x[i]),
         .y       (slot_y[i])
      );
   end

   // compare-based select keeps the mux legal when N_SAMPLES is not a power of two
   always_comb begin
      sel_x = '0;
      sel_y = '0;
      for (int i = 0; i < N_SAMPLES; i++) begin
         if (idx == IDX_W'(i)) begin
            sel_x = slot_x[i];
            sel_y = slot_y[i];
         end
      end
   end

   assign bus.in_ready  = (state == S_LOAD);
   assign bus.out_valid = (state == S_REPLAY);
   assign bus.done      = (state == S_DONE);
   assign bus.out_last  = (state == S_REPLAY) && (idx == IDX_W'(N_SAMPLES - 1));
   assign bus.out_x     = sel_x;
   assign bus.out_y     = sel_y;
   assign bus.out_idx   = idx;
   assign bus.out_epoch = epoch;
endmodule

// File: tb/tb_perceptron_sample_loader.sv
// Directed bench for perceptron_sample_loader: load, replay, backpressure,
// clear and asynchronous reset.
module tb_perceptron_sample_loader;
   localparam int INP_DIM = 2;
   localparam int N_S     = 3;
   localparam int N_E     = 4;

   logic clk = 1'b0;
   logic rst_n;
   logic clear;
   int   total = 0;
   int   bad   = 0;

   logic [7:0] set_a [9] = '{8'h02, 8'h03, 8'h00, 8'h04, 8'h05, 8'h01, 8'h01, 8'h02, 8'h01};
   logic [7:0] set_c [9] = '{8'h10, 8'h11, 8'hFF, 8'h20, 8'h21, 8'h01, 8'h30, 8'h31, 8'h80};

   always #5 clk = ~clk;

   perceptron_sample_loader_if #(.INP_DIM(INP_DIM), .N_SAMPLES(N_S), .EPOCHS(N_E)) bus ();

   perceptron_sample_loader #(.INP_DIM(INP_DIM), .N_SAMPLES(N_S), .EPOCHS(N_E)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [7:0] d [9], input bit bp);
      for (int i = 0; i < 9; i++) begin
         if (bp) begin
            repeat ($urandom_range(0, 2)) begin
               bus.in_valid = 1'b0;
               bus.in_data  = 8'($urandom);
               chk("load_rdy_gap", bus.in_ready, 1);
               step();
            end
         end
         bus.in_valid = 1'b1;
         bus.in_data  = d[i];
         chk("load_rdy", bus.in_ready, 1);
         chk("load_ov", bus.out_valid, 0);
         step();
      end
      bus.in_valid = 1'b0;
   endtask

   // Walks the expected replay order; stops after n transfers.
   task automatic replay(input logic [7:0] d [9], input int n, input bit bp, input bit junk);
      int cnt = 0;
      for (int e = 0; e < N_E; e++) begin
         for (int i = 0; i < N_S; i++) begin
            int guard = 0;
            if (cnt == n) return;
            do begin
               bus.out_ready = (bp && guard < 8) ? 1'($urandom_range(0, 1)) : 1'b1;
               bus.in_valid  = junk;
               bus.in_data   = 8'hFF;
               chk("rp_ov", bus.out_valid, 1);
               chk("rp_rdy", bus.in_ready, 0);
               chk("rp_x", bus.out_x, {d[3*i+1], d[3*i]});
               chk("rp_y", bus.out_y, d[3*i+2]);
               chk("rp_idx", bus.out_idx, i);
               chk("rp_epoch", bus.out_epoch, e);
               chk("rp_last", bus.out_last, (i == N_S - 1));
               chk("rp_done", bus.done, 0);
               step();
               guard++;
            end while (!bus.out_ready);
            cnt++;
         end
      end
   endtask

   task automatic chk_done();
      chk("dn_done", bus.done, 1);
      chk("dn_ov", bus.out_valid, 0);
      chk("dn_rdy", bus.in_ready, 0);
      chk("dn_last", bus.out_last, 0);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_rdy"}, bus.in_ready, 1);
      chk({tag, "_ov"}, bus.out_valid, 0);
      chk({tag, "_done"}, bus.done, 0);
      chk({tag, "_last"}, bus.out_last, 0);
      chk({tag, "_idx"}, bus.out_idx, 0);
      chk({tag, "_ep"}, bus.out_epoch, 0);
   endtask

   initial begin
      rst_n         = 1'b0;
      clear         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = 8'h00;
      bus.out_ready = 1'b0;
      #2;
      chk_idle("rst");
      chk("rst_x", bus.out_x, 0);
      chk("rst_y", bus.out_y, 0);
      #10 rst_n = 1'b1;
      step();
      chk_idle("post_rst");

      // plain load, then held backpressure, then full replay
      load(set_a, 1'b0);
      bus.out_ready = 1'b0;
      chk("ld_rdy_drop", bus.in_ready, 0);
      chk("ld_ov", bus.out_valid, 1);
      chk("ld_x", bus.out_x, 16'h0302);
      chk("ld_y", bus.out_y, 8'h00);
      chk("ld_idx", bus.out_idx, 0);
      step();
      chk("hold_x", bus.out_x, 16'h0302);
      chk("hold_idx", bus.out_idx, 0);
      chk("hold_ov", bus.out_valid, 1);
      replay(set_a, 12, 1'b0, 1'b0);
      bus.out_ready = 1'b0;
      chk_done();
      step();
      chk_done();

      // random gaps on both sides, junk bytes offered during replay
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk_idle("clr1");
      load(set_a, 1'b1);
      replay(set_a, 12, 1'b1, 1'b1);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      chk_done();

      // clear mid-load; the byte offered with clear must be dropped
      clear = 1'b1;
      step();
      clear = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 8'hA0 + 8'(i);
         step();
      end
      bus.in_data = 8'h77;
      clear       = 1'b1;
      step();
      clear        = 1'b0;
      bus.in_valid = 1'b0;
      chk_idle("clr2");
      load(set_c, 1'b0);
      chk("c_x", bus.out_x, 16'h1110);
      chk("c_y", bus.out_y, 8'hFF);
      replay(set_c, 12, 1'b0, 1'b0);
      bus.out_ready = 1'b0;
      chk_done();

      // async reset in the middle of epoch 2
      clear = 1'b1;
      step();
      clear = 1'b0;
      load(set_c, 1'b0);
      replay(set_c, 7, 1'b0, 1'b0);
      bus.out_ready = 1'b0;
      chk("pre_rst_ep", bus.out_epoch, 2);
      chk("pre_rst_idx", bus.out_idx, 1);
      #3 rst_n = 1'b0;
      #1;
      chk_idle("arst");
      chk("arst_x", bus.out_x, 0);
      chk("arst_y", bus.out_y, 0);
      step();
      rst_n = 1'b1;
      step();
      chk_idle("arst_rel");
      load(set_a, 1'b0);
      replay(set_a, 12, 1'b0, 1'b0);
      bus.out_ready = 1'b0;
      chk_done();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
